multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 111 +++++++++++
 tb/tb_multicycle_controller.sv | 134 +++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle CPU control FSM with memory wait timeout and retire counter
module multicycle_controller #(
   parameter int WAIT_LIMIT = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [10:0] instruction,
   input  logic        zero,
   input  logic        memReady,
   output logic        pcWrite,
   output logic        irWrite,
   output logic        memRead,
   output logic        memWrite,
   output logic        regWriteFlag,
   output logic        memToReg,
   output logic        aluSRC,
   output logic        reg2Loc,
   output logic        pcSrc,
   output logic        unconditionalBranch,
   output logic [1:0]  aluOP,
   output logic [2:0]  state,
   output logic        fault,
   output logic [15:0] retired
);
   localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2, MEMORY = 3'd3,
                          WRITEBACK = 3'd4, FAULT = 3'd7;
   localparam int WW = $clog2(WAIT_LIMIT + 1) > 0 ? $clog2(WAIT_LIMIT + 1) : 1;
   localparam logic [WW-1:0] LIMIT = WW'(WAIT_LIMIT);
   localparam int R = 4, LD = 3, ST = 2, CB = 1, BR = 0;

   logic [2:0]    next;
   logic [10:0]   opcode;
   logic [WW-1:0] wait_cnt;
   logic [4:0]    k, nk;
   logic          timeout, go;

   // one-hot instruction class: {R-type, LDUR, STUR, CBZ, B}; all zero means illegal
   function automatic logic [4:0] kind(input logic [10:0] i);
      kind = {i == 11'b10001011000 || i == 11'b11001011000 || i == 11'b10001010000 ||
              i == 11'b10101010000, i == 11'b11111000010, i == 11'b11111000000,
              i[10:3] == 8'b10110100, i[10:5] == 6'b000101};
   endfunction

   assign k = kind(opcode);
   assign nk = kind(instruction);
   assign timeout = !memReady && wait_cnt == LIMIT;
   assign go = memReady && !reset;
   assign fault = state == FAULT && !reset;

   // reset forces FETCH-shaped outputs even while the state register still holds the old code
   always_comb begin
      next = FAULT;
      pcWrite = 1'b0;
      irWrite = 1'b0;
      memRead = 1'b0;
      memWrite = 1'b0;
      regWriteFlag = 1'b0;
      memToReg = 1'b0;
      aluSRC = 1'b0;
      reg2Loc = 1'b0;
      pcSrc = 1'b0;
      unconditionalBranch = 1'b0;
      aluOP = 2'b00;
      case (reset ? FETCH : state)
         FETCH: begin
            memRead = 1'b1;
            irWrite = go;
            pcWrite = go;
            next = memReady ? DECODE : timeout ? FAULT : FETCH;
         end
         DECODE: next = |nk ? EXECUTE : FAULT;
         EXECUTE: begin
            aluSRC = k[LD] | k[ST];
            reg2Loc = k[ST] | k[CB];
            aluOP = k[R] ? 2'b10 : k[CB] ? 2'b01 : 2'b00;
            pcWrite = k[BR] | (k[CB] & zero);
            pcSrc = k[BR] | (k[CB] & zero);
            unconditionalBranch = k[BR];
            next = k[R] ? WRITEBACK : (k[LD] | k[ST]) ? MEMORY : (k[CB] | k[BR]) ? FETCH : FAULT;
         end
         MEMORY: begin
            memRead = k[LD];
            memWrite = k[ST];
            reg2Loc = k[ST];
            next = !(k[LD] | k[ST]) ? FAULT : memReady ? (k[LD] ? WRITEBACK : FETCH) :
                   timeout ? FAULT : MEMORY;
         end
         WRITEBACK: begin
            regWriteFlag = 1'b1;
            memToReg = k[LD];
            next = FETCH;
         end
         default: next = FAULT;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= FETCH;
         opcode <= '0;
         wait_cnt <= '0;
         retired <= '0;
      end else begin
         state <= next;
         if (state == DECODE) opcode <= instruction;
         wait_cnt <= (next == state && (state == FETCH || state == MEMORY)) ? wait_cnt + WW'(1) : '0;
         if (next == FETCH && (state == EXECUTE || state == MEMORY || state == WRITEBACK))
            retired <= retired + 16'd1;
      end
   end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle vectors feeding a scoreboard queue checked by a monitor
module tb_multicycle_controller;
   logic        clock = 1'b0, reset = 1'b1, zero = 1'b0, memReady = 1'b1;
   logic [10:0] instruction = '0;
   logic        pcWrite, irWrite, memRead, memWrite, regWriteFlag, memToReg;
   logic        aluSRC, reg2Loc, pcSrc, unconditionalBranch, fault;
   logic [1:0]  aluOP;
   logic [2:0]  state;
   logic [15:0] retired;
   int checks = 0, failures = 0;

   localparam logic [10:0] ADD = 11'b10001011000, SUB = 11'b11001011000, LDUR = 11'b11111000010,
                           STUR = 11'b11111000000, CBZ = 11'b10110100000, B = 11'b00010100000,
                           BAD = 11'b00000000000;
   // strobe order: pcWrite irWrite memRead memWrite regWriteFlag memToReg aluSRC reg2Loc pcSrc uncondBranch
   localparam logic [9:0] FM = 10'b0010000000, FR = 10'b1110000000;

   typedef struct {
      string       n;
      logic [2:0]  st;
      logic [9:0]  sb;
      logic [1:0]  op;
      logic        f;
      logic [15:0] ret;
   } exp_t;
   exp_t q[$];

   multicycle_controller #(.WAIT_LIMIT(15)) dut (
      .clock(clock), .reset(reset), .instruction(instruction), .zero(zero), .memReady(memReady),
      .pcWrite(pcWrite), .irWrite(irWrite), .memRead(memRead), .memWrite(memWrite),
      .regWriteFlag(regWriteFlag), .memToReg(memToReg), .aluSRC(aluSRC), .reg2Loc(reg2Loc),
      .pcSrc(pcSrc), .unconditionalBranch(unconditionalBranch), .aluOP(aluOP), .state(state),
      .fault(fault), .retired(retired)
   );

   always #5 clock = ~clock;

   initial begin
      logic [9:0] sb;
      exp_t e;
      forever begin
         @(negedge clock);
         if (q.size() != 0) begin
            e = q.pop_front();
            sb = {pcWrite, irWrite, memRead, memWrite, regWriteFlag, memToReg, aluSRC, reg2Loc,
                  pcSrc, unconditionalBranch};
            checks++;
            if (state !== e.st || sb !== e.sb || aluOP !== e.op || fault !== e.f || retired !== e.ret) begin
               failures++;
               $display("FAIL %s: got state=%0d strobes=%b aluOP=%b fault=%b retired=%0d, want state=%0d strobes=%b aluOP=%b fault=%b retired=%0d",
                        e.n, state, sb, aluOP, fault, retired, e.st, e.sb, e.op, e.f, e.ret);
            end
         end
      end
   end

   task automatic step(input string n, input logic r, input logic [10:0] ins, input logic z,
                       input logic mr, input logic [2:0] st, input logic [9:0] sb,
                       input logic [1:0] op, input logic f, input logic [15:0] ret);
      exp_t e;
      reset = r;
      instruction = ins;
      zero = z;
      memReady = mr;
      e.n = n;
      e.st = st;
      e.sb = sb;
      e.op = op;
      e.f = f;
      e.ret = ret;
      q.push_back(e);
      @(posedge clock);
      #1;
   endtask

   task automatic rtype(input string n, input logic [10:0] ins, input logic [15:0] ret);
      step({n, "_fetch"}, 0, ins, 0, 1, 0, FR, 2'b00, 0, ret);
      step({n, "_decode"}, 0, ins, 0, 1, 1, 10'b0, 2'b00, 0, ret);
      step({n, "_exec"}, 0, ins, 0, 1, 2, 10'b0, 2'b10, 0, ret);
      step({n, "_wb"}, 0, ins, 0, 1, 4, 10'b0000100000, 2'b00, 0, ret);
   endtask

   initial begin
      @(posedge clock);
      @(posedge clock);
      #1;
      rtype("add", ADD, 0);
      step("ldur_fetch", 0, LDUR, 0, 1, 0, FR, 2'b00, 0, 1);
      step("ldur_decode", 0, LDUR, 0, 1, 1, 10'b0, 2'b00, 0, 1);
      step("ldur_exec", 0, LDUR, 0, 1, 2, 10'b0000001000, 2'b00, 0, 1);
      for (int i = 0; i < 3; i++) step("ldur_mem_wait", 0, LDUR, 0, 0, 3, FM, 2'b00, 0, 1);
      step("ldur_mem_done", 0, LDUR, 0, 1, 3, FM, 2'b00, 0, 1);
      step("ldur_wb", 0, LDUR, 0, 1, 4, 10'b0000110000, 2'b00, 0, 1);
      step("stur_fetch", 0, STUR, 0, 1, 0, FR, 2'b00, 0, 2);
      step("stur_decode", 0, STUR, 0, 1, 1, 10'b0, 2'b00, 0, 2);
      step("stur_exec", 0, STUR, 0, 1, 2, 10'b0000001100, 2'b00, 0, 2);
      step("stur_mem", 0, STUR, 0, 1, 3, 10'b0001000100, 2'b00, 0, 2);
      step("cbz1_fetch", 0, CBZ, 1, 1, 0, FR, 2'b00, 0, 3);
      step("cbz1_decode", 0, CBZ, 1, 1, 1, 10'b0, 2'b00, 0, 3);
      step("cbz1_exec", 0, CBZ, 1, 1, 2, 10'b1000000110, 2'b01, 0, 3);
      step("cbz0_fetch", 0, CBZ, 0, 1, 0, FR, 2'b00, 0, 4);
      step("cbz0_decode", 0, CBZ, 0, 1, 1, 10'b0, 2'b00, 0, 4);
      step("cbz0_exec", 0, CBZ, 0, 1, 2, 10'b0000000100, 2'b01, 0, 4);
      step("b_fetch", 0, B, 0, 1, 0, FR, 2'b00, 0, 5);
      step("b_decode", 0, B, 0, 1, 1, 10'b0, 2'b00, 0, 5);
      step("b_exec", 0, B, 0, 1, 2, 10'b1000000011, 2'b00, 0, 5);
      rtype("sub", SUB, 6);
      for (int i = 0; i < 15; i++) step("fetch_wait", 0, ADD, 0, 0, 0, FM, 2'b00, 0, 7);
      rtype("limit_ok", ADD, 7);
      for (int i = 0; i < 16; i++) step("fetch_wait_to", 0, ADD, 0, 0, 0, FM, 2'b00, 0, 8);
      for (int i = 0; i < 3; i++) step("timeout_fault", 0, ADD, 1, 1, 7, 10'b0, 2'b00, 1, 8);
      step("reset_in_fault", 1, ADD, 0, 1, 7, FM, 2'b00, 0, 8);
      step("bad_fetch", 0, BAD, 0, 1, 0, FR, 2'b00, 0, 0);
      step("bad_decode", 0, BAD, 0, 1, 1, 10'b0, 2'b00, 0, 0);
      for (int i = 0; i < 10; i++) step("bad_fault", 0, BAD, 1, 1, 7, 10'b0, 2'b00, 1, 0);
      step("reset_bad", 1, BAD, 0, 1, 7, FM, 2'b00, 0, 0);
      rtype("add2", ADD, 0);
      step("stur2_fetch", 0, STUR, 0, 1, 0, FR, 2'b00, 0, 1);
      step("stur2_decode", 0, STUR, 0, 1, 1, 10'b0, 2'b00, 0, 1);
      step("stur2_exec", 0, STUR, 0, 1, 2, 10'b0000001100, 2'b00, 0, 1);
      step("stur2_mem", 0, STUR, 0, 0, 3, 10'b0001000100, 2'b00, 0, 1);
      step("reset_mid_mem", 1, STUR, 0, 0, 3, FM, 2'b00, 0, 1);
      step("after_reset", 0, STUR, 0, 0, 0, FM, 2'b00, 0, 0);
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
